// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC/MEM -> WB, plus a sticky HALT.
// Latency FETCH-to-FETCH: ALU 4, NOP 3, LOAD/STORE 3+N cycles (N = MEM cycles incl. the ack cycle).
// Backpressure: mem_req is held in MEM until mem_ack, with no timeout; mem_ack outside MEM is ignored.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        alu_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic [2:0]  rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic [7:0]  mem_addr,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t      state;
    logic [31:0] ir;
    logic [2:0]  opcode;
    logic        is_store;
    logic        writes_reg;
    logic        unused_ir;

    assign opcode     = ir[2:0];
    assign is_store   = (opcode == OP_STORE);
    assign writes_reg = (opcode == OP_ALU) || (opcode == OP_LOAD);

    assign rd       = ir[10:8];
    assign rs1      = ir[15:13];
    assign rs2      = ir[21:19];
    assign mem_addr = ir[20:13];
    assign unused_ir = ^{ir[31:22], ir[12:11], ir[7:3]};

    // Outputs are registered for the state being entered, so each one is
    // a pure function of the state/IR flops with no path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ir      <= 32'd0;
            retired <= 16'd0;
            pc_en   <= 1'b0;
            alu_en  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            reg_we  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            pc_en   <= 1'b0;
            alu_en  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            reg_we  <= 1'b0;
            halted  <= 1'b0;
            case (state)
                S_FETCH: begin
                    ir    <= instruction;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_ALU: begin
                            state  <= S_EXEC;
                            alu_en <= 1'b1;
                        end
                        OP_LOAD, OP_STORE: begin
                            state   <= S_MEM;
                            mem_req <= 1'b1;
                            mem_we  <= is_store;
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        default: begin
                            state   <= S_WB;
                            pc_en   <= 1'b1;
                            reg_we  <= writes_reg;
                            retired <= retired + 16'd1;
                        end
                    endcase
                end
                S_EXEC: begin
                    state   <= S_WB;
                    pc_en   <= 1'b1;
                    reg_we  <= writes_reg;
                    retired <= retired + 16'd1;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state   <= S_WB;
                        pc_en   <= 1'b1;
                        reg_we  <= writes_reg;
                        retired <= retired + 16'd1;
                    end else begin
                        mem_req <= 1'b1;
                        mem_we  <= is_store;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of single-instruction vectors scored through a queue,
// plus hand sequences for HALT, reset during MEM and retired-counter wrap.
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        mem_ack;
    logic        pc_en, alu_en, mem_req, mem_we, reg_we, halted;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  mem_addr;
    logic [15:0] retired;

    control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .mem_ack     (mem_ack),
        .pc_en       (pc_en),
        .alu_en      (alu_en),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .reg_we      (reg_we),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .mem_addr    (mem_addr),
        .halted      (halted),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          ack_delay;
        logic        noise;
        int          cycles;
        int          alu;
        int          mem;
        int          we;
        logic        reg_we;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [7:0]  addr;
    } vec_t;

    typedef struct {
        string       tag;
        int          cycles;
        int          alu;
        int          mem;
        int          we;
        logic        reg_we;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [7:0]  addr;
        logic [15:0] retired;
    } sb_t;

    sb_t         sb[$];
    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_retired = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Called at the falling edge of a FETCH cycle; returns at the falling edge of the next FETCH.
    task automatic run_instr(input vec_t v, input string tag);
        sb_t         e;
        int          cyc, alu, mem, we;
        bit          done;
        logic        g_reg_we;
        logic [2:0]  g_rd, g_rs1, g_rs2;
        logic [7:0]  g_addr;
        logic [15:0] g_ret;
        check({tag, " fetch_idle"}, {26'd0, pc_en, alu_en, mem_req, mem_we, reg_we, halted}, 32'd0);
        instruction = v.instr;
        mem_ack     = v.noise;
        exp_retired = exp_retired + 16'd1;
        e.tag = tag;       e.cycles = v.cycles; e.alu = v.alu; e.mem = v.mem; e.we = v.we;
        e.reg_we = v.reg_we; e.rd = v.rd; e.rs1 = v.rs1; e.rs2 = v.rs2; e.addr = v.addr;
        e.retired = exp_retired;
        sb.push_back(e);
        cyc = 1; alu = 0; mem = 0; we = 0; done = 0;
        g_reg_we = 1'b0; g_rd = 3'd0; g_rs1 = 3'd0; g_rs2 = 3'd0; g_addr = 8'd0; g_ret = 16'd0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            instruction = 32'hFFFF_FFFF;
            if (alu_en)  alu++;
            if (mem_req) mem++;
            if (mem_we)  we++;
            if (pc_en) begin
                done     = 1;
                g_reg_we = reg_we;
                g_rd     = rd;
                g_rs1    = rs1;
                g_rs2    = rs2;
                g_addr   = mem_addr;
                g_ret    = retired;
            end
            mem_ack = (cyc == 2) ? v.noise : 1'b0;
            if (mem_req && mem >= v.ack_delay) mem_ack = 1'b1;
        end
        e = sb.pop_front();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no pc_en within %0d cycles, want %0d", e.tag, cyc, e.cycles);
        end else begin
            check({e.tag, " cycles"},  cyc,      e.cycles);
            check({e.tag, " alu_en"},  alu,      e.alu);
            check({e.tag, " mem_req"}, mem,      e.mem);
            check({e.tag, " mem_we"},  we,       e.we);
            check({e.tag, " reg_we"},  g_reg_we, e.reg_we);
            check({e.tag, " rd"},      g_rd,     e.rd);
            check({e.tag, " rs1"},     g_rs1,    e.rs1);
            check({e.tag, " rs2"},     g_rs2,    e.rs2);
            check({e.tag, " addr"},    g_addr,   e.addr);
            check({e.tag, " retired"}, g_ret,    e.retired);
        end
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   viol;
        vec_t nop;
        //          instr         dly nz cyc alu mem we rwe rd rs1 rs2 addr
        vecs[0] = '{32'h0008_2000, 0, 0, 4, 1, 0, 0, 1, 0, 1, 1, 8'h41};
        vecs[1] = '{32'h0000_2104, 3, 0, 6, 0, 3, 0, 1, 1, 1, 0, 8'h01};
        vecs[2] = '{32'h0000_4205, 1, 0, 4, 0, 1, 1, 0, 2, 2, 0, 8'h02};
        vecs[3] = '{32'h0000_0003, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00};
        vecs[4] = '{32'h0030_A700, 0, 1, 4, 1, 0, 0, 1, 7, 5, 6, 8'h85};
        vecs[5] = '{32'h001F_E005, 2, 1, 5, 0, 2, 2, 0, 0, 7, 3, 8'hFF};
        vecs[6] = '{32'h0000_0006, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00};
        vecs[7] = '{32'h0000_0F0C, 1, 1, 4, 0, 1, 0, 1, 7, 0, 0, 8'h00};
        nop     = '{32'h0000_0001, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00};

        rst = 1'b1;
        instruction = 32'd0;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_idle", {26'd0, pc_en, alu_en, mem_req, mem_we, reg_we, halted}, 32'd0);
        check("reset_retired", retired, 16'd0);
        mem_ack = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_instr(vecs[i], $sformatf("vec%0d", i));

        // HALT is sticky: no strobes for 20 cycles despite ack noise, only rst clears it.
        instruction = 32'h0000_0007;
        @(negedge clk);
        instruction = 32'd0;
        @(negedge clk);
        check("halt_flag", halted, 1'b1);
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            mem_ack = k[0];
            @(negedge clk);
            if (pc_en || alu_en || mem_req || mem_we || reg_we || !halted) viol++;
        end
        check("halt_quiet", viol, 0);
        check("halt_retired", retired, exp_retired);
        mem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("halt_rst_clear", halted, 1'b0);
        check("halt_rst_retired", retired, 16'd0);
        exp_retired = 16'd0;
        run_instr(vecs[0], "post_halt");

        // Reset in the second MEM cycle while ack is asserted; stray ack continues into FETCH.
        instruction = 32'h0000_2104;
        mem_ack = 1'b0;
        @(negedge clk);
        instruction = 32'hFFFF_FFFF;
        @(negedge clk);
        check("midmem_req1", mem_req, 1'b1);
        @(negedge clk);
        check("midmem_req2", mem_req, 1'b1);
        rst = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midmem_drop", {27'd0, mem_req, mem_we, pc_en, alu_en, reg_we}, 32'd0);
        check("midmem_retired", retired, 16'd0);
        exp_retired = 16'd0;
        run_instr(vecs[4], "after_midmem");

        // Preload the counter just below the top and retire two NOPs across the wrap.
        force dut.retired = 16'hFFFE;
        #1;
        release dut.retired;
        check("wrap_preload", retired, 16'hFFFE);
        exp_retired = 16'hFFFE;
        run_instr(nop, "wrap_ffff");
        run_instr(nop, "wrap_0000");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 SHALL have one clock and one reset: clk is the single clock, and rst is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clk only.
REQ-005 instruction  input  32  word from instruction memory addressed by current pc.
REQ-006 mem_ack  input  1  data memory completion; meaningful only while mem_req=1.
REQ-007 pc_en  output  1  one-cycle pulse; program counter advances by 1.
REQ-008 alu_en  output  1  ALU operation strobe.
REQ-009 mem_req  output  1  data memory request, held until mem_ack.
REQ-010 mem_we  output  1  store qualifier; valid only with mem_req.
REQ-011 reg_we  output  1  register file write enable.
REQ-012 rd, rs1, rs2  output  3 each  register indices from IR[10:8], IR[15:13], IR[21:19].
REQ-013 mem_addr  output  8  data address from IR[20:13].
REQ-014 halted  output  1  high while in HALT.
REQ-015 retired  output  16  count of retired instructions.

Function
REQ-016 SHALL be a Moore FSM: every output SHALL be a function of the state register and IR only; no combinational path from instruction or mem_ack to any output.
REQ-017 IR (32 bit) SHALL load instruction only on the clk edge leaving FETCH; it SHALL hold its value at all other times.
REQ-018 Opcode SHALL be IR[2:0]: 000 ALU, 100 LOAD, 101 STORE, 111 HALT; all other values are NOP.
REQ-019 FETCH: all strobes SHALL be 0; next state SHALL be DECODE unconditionally.
REQ-020 DECODE: the ALU opcode SHALL go to EXEC, LOAD/STORE to MEM, HALT to HALT, and NOP to WB.
REQ-021 EXEC: alu_en=1 for exactly one cycle; next state SHALL be WB.
REQ-022 MEM: mem_req=1, mem_we=1 iff STORE; SHALL stay in MEM while mem_ack=0 with no bound on the wait; on mem_ack=1 SHALL go to WB.
REQ-023 WB: pc_en=1 for one cycle; reg_we=1 iff opcode is ALU or LOAD; next state SHALL be FETCH.
REQ-024 HALT: halted=1; all strobes 0; pc_en never asserted; SHALL remain until rst.
REQ-025 retired SHALL increment by 1 on each WB cycle and wrap 0xFFFF->0x0000.
REQ-026 Latency: ALU=4 cycles, NOP=3, LOAD/STORE=3+N where N>=1 is the number of MEM cycles, FETCH to FETCH.
REQ-027 mem_ack while not in MEM SHALL be ignored, with no state or output change.
REQ-028 rd/rs1/rs2/mem_addr SHALL be driven from IR continuously; they are valid from DECODE through WB.

Reset
REQ-029 On rising clk with rst=1: state<=FETCH, IR<=0, retired<=0.
REQ-030 rst SHALL take priority over every transition, including mid-MEM and HALT.
REQ-031 All strobes and halted SHALL be 0 from the cycle after the reset edge.
REQ-032 A pending mem_req SHALL drop after the reset edge regardless of mem_ack.
REQ-033 The first FETCH after reset release SHALL sample instruction at pc=0.

Verification
REQ-034 ALU: instruction=0x00082000 -> DECODE, then alu_en=1 one cycle, then WB with reg_we=1, pc_en=1, rd=0, rs1=1, rs2=1, retired=1.
REQ-035 LOAD with 3-cycle ack delay: instruction=0x00002104 -> mem_req=1, mem_we=0 for 3 cycles, mem_addr=0x01, then WB with reg_we=1, rd=1; total 6 cycles.
REQ-036 STORE: instruction=0x00004205, mem_ack=1 immediately -> one MEM cycle with mem_we=1, mem_addr=0x02; WB with reg_we=0, pc_en=1.
REQ-037 HALT/NOP: opcode 011 -> retires in 3 cycles with reg_we=0; opcode 111 -> halted=1, pc_en stays 0 for 20 cycles; rst -> halted=0.
REQ-038 Reset mid-MEM: rst asserted during the 2nd MEM cycle -> mem_req=0 the next cycle, state FETCH, retired=0; stray mem_ack in FETCH is ignored.
REQ-039 Wrap: preload 65535 NOP retirements -> retired=0xFFFF; next WB -> retired=0x0000.
